// File: rtl/bank_pkg.sv
// Shared bank-select types and helpers for the 16-bank write and read paths.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package bank_pkg;

    localparam int SEL_W    = 4;
    localparam int NUM_BANK = 1 << SEL_W;

    typedef logic [SEL_W-1:0]    bank_sel_t;
    typedef logic [NUM_BANK-1:0] bank_onehot_t;

    // Binary bank index to one-hot bank vector.
    function automatic bank_onehot_t sel2onehot(input bank_sel_t sel);
        bank_onehot_t oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bank_seq_counter.sv
// Wrapping bank sequence counter with clear and increment; clear wins over increment.
// Latency: new value visible one cycle after clr/inc is sampled.
// Backpressure: none; the owner gates inc with its own handshake.
module bank_seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then natural wrap at 2**W on increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bank_write_dispatch.sv
// Registers one word and dispatches it to one of 16 banks with a one-hot write enable.
// Latency: word accepted in cycle N is written in cycle N+1 (later if its bank stalls).
// Backpressure: in_ready drops while the pending word's bank stalls; other banks' stalls ignored.
// Optional statistics counters are built when BANK_WRITE_DISPATCH_STAT_EN is defined.
// Bank count and select width come from bank_pkg (SEL_W=4, NUM_BANK=16).
module bank_write_dispatch
    import bank_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic [AW-1:0]       in_addr,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_auto,
    input  logic                cnt_clr,
    input  logic [NUM_BANK-1:0] bank_stall,
    output logic [NUM_BANK-1:0] wr_en,
    output logic [DW-1:0]       wr_data,
    output logic [AW-1:0]       wr_addr,
    output logic [SEL_W-1:0]    seq_cnt
`ifdef BANK_WRITE_DISPATCH_STAT_EN
    ,
    output logic [15:0]         stat_wr_cnt,
    output logic [15:0]         stat_stall_cnt
`endif
);

    // Pending register: one word in flight toward its bank.
    logic            pend_valid_q, pend_valid_d;
    bank_sel_t       pend_sel_q,   pend_sel_d;
    logic [DW-1:0]   wr_data_q,    wr_data_d;
    logic [AW-1:0]   wr_addr_q,    wr_addr_d;

    bank_sel_t       eff_sel;
    logic            fire;
    logic            accept;
    logic            ready;

    // Auto mode uses the counter value before any same-cycle clear or increment.
    assign eff_sel = in_auto ? seq_cnt : in_sel;

    // Handshake: the pending word leaves when its own bank is free, freeing the slot same cycle.
    always_comb begin
        fire   = pend_valid_q && !bank_stall[pend_sel_q];
        ready  = !pend_valid_q || fire;
        accept = in_valid && ready;
    end

    // Pending register next state: load on accept, empty on fire-only, otherwise hold.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_sel_d   = pend_sel_q;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = eff_sel;
            wr_data_d    = in_data;
            wr_addr_d    = in_addr;
        end else if (fire) begin
            pend_valid_d = 1'b0;
        end
    end

    // Pending register; reset drops any word still waiting on a stalled bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_sel_q   <= '0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_sel_q   <= pend_sel_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
        end
    end

    // Bank sequence counter advances only on auto-mode accepts.
    bank_seq_counter #(
        .W (SEL_W)
    ) u_seq_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (accept && in_auto),
        .cnt (seq_cnt)
    );

    // Write enable depends only on registered state and the target bank's stall.
    always_comb begin
        wr_en = '0;
        if (fire) begin
            wr_en = sel2onehot(pend_sel_q);
        end
    end

    assign in_ready = ready;
    assign wr_data  = wr_data_q;
    assign wr_addr  = wr_addr_q;

`ifdef BANK_WRITE_DISPATCH_STAT_EN
    logic [15:0] stat_wr_q,    stat_wr_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    // Saturating event counters; cnt_clr zeroes them alongside the sequence counter.
    always_comb begin
        stat_wr_d    = stat_wr_q;
        stat_stall_d = stat_stall_q;
        if (cnt_clr) begin
            stat_wr_d    = '0;
            stat_stall_d = '0;
        end else begin
            if (fire && (stat_wr_q != 16'hFFFF)) begin
                stat_wr_d = stat_wr_q + 16'd1;
            end
            if (pend_valid_q && !fire && (stat_stall_q != 16'hFFFF)) begin
                stat_stall_d = stat_stall_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_wr_q    <= stat_wr_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_wr_cnt    = stat_wr_q;
    assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_bank_write_dispatch.sv
// Directed test of bank_write_dispatch: burst, stall, ignored stall, mixed select, clear, reset.
// Latency: checks sample one time unit after inputs settle, between clock edges.
// Backpressure: exercised through bank_stall on the pending and on unrelated banks.
module tb_bank_write_dispatch;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic [3:0]    in_sel;
    logic          in_auto;
    logic          cnt_clr;
    logic [15:0]   bank_stall;
    logic [15:0]   wr_en;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic [3:0]    seq_cnt;
`ifdef BANK_WRITE_DISPATCH_STAT_EN
    logic [15:0]   stat_wr_cnt;
    logic [15:0]   stat_stall_cnt;
`endif

    int total;
    int bad;

    bank_write_dispatch #(
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_sel     (in_sel),
        .in_auto    (in_auto),
        .cnt_clr    (cnt_clr),
        .bank_stall (bank_stall),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .seq_cnt    (seq_cnt)
`ifdef BANK_WRITE_DISPATCH_STAT_EN
        ,
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_addr    = '0;
        in_sel     = '0;
        in_auto    = 1'b0;
        cnt_clr    = 1'b0;
        bank_stall = '0;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wr_en",    32'(wr_en),    32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_seq_cnt",  32'(seq_cnt),  32'h0);
        chk("rst_wr_data",  wr_data,       32'h0);
        chk("rst_wr_addr",  32'(wr_addr),  32'h0);

        // Auto burst of 16 words: bank k written one cycle after word k is accepted.
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_auto  = 1'b1;
            in_data  = 32'h100 + 32'(k);
            in_addr  = AW'(k);
            #1;
            chk("burst_ready", 32'(in_ready), 32'h1);
            if (k > 0) begin
                chk("burst_wr_en",   32'(wr_en), 32'h1 << (k - 1));
                chk("burst_wr_data", wr_data,    32'h100 + 32'(k - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("burst_last_wr_en",   32'(wr_en),   32'h8000);
        chk("burst_last_wr_data", wr_data,      32'h10F);
        chk("burst_last_wr_addr", 32'(wr_addr), 32'hF);
        chk("burst_seq_wrap",     32'(seq_cnt), 32'h0);
        tick();
        chk("burst_idle_wr_en",   32'(wr_en),   32'h0);
        chk("burst_idle_data",    wr_data,      32'h10F);

        // Explicit bank 5 stalled for 3 cycles.
        in_valid   = 1'b1;
        in_auto    = 1'b0;
        in_sel     = 4'd5;
        in_data    = 32'hAAA5;
        in_addr    = 10'h055;
        bank_stall = 16'h0020;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEAD;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_wr_en",    32'(wr_en),    32'h0);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        bank_stall = '0;
        #1;
        chk("stall_rel_wr_en",   32'(wr_en),    32'h0020);
        chk("stall_rel_wr_data", wr_data,       32'hAAA5);
        chk("stall_rel_wr_addr", 32'(wr_addr),  32'h055);
        chk("stall_rel_ready",   32'(in_ready), 32'h1);
        tick();
        chk("stall_once_wr_en",  32'(wr_en),    32'h0);
        chk("stall_seq_cnt",     32'(seq_cnt),  32'h0);

        // Pending on bank 3 while only bank 2 stalls.
        in_valid = 1'b1;
        in_sel   = 4'd3;
        in_data  = 32'h333;
        in_addr  = 10'h003;
        tick();
        in_valid   = 1'b0;
        bank_stall = 16'h0004;
        #1;
        chk("other_stall_wr_en", 32'(wr_en),    32'h0008);
        chk("other_stall_ready", 32'(in_ready), 32'h1);
        tick();
        bank_stall = '0;

        // Mixed sequence: auto, explicit 9, auto.
        in_valid = 1'b1;
        in_auto  = 1'b1;
        in_data  = 32'hA0;
        tick();
        in_auto  = 1'b0;
        in_sel   = 4'd9;
        in_data  = 32'hA1;
        #1;
        chk("mix_bank0", 32'(wr_en), 32'h0001);
        tick();
        in_auto = 1'b1;
        in_data = 32'hA2;
        #1;
        chk("mix_bank9",   32'(wr_en),   32'h0200);
        chk("mix_seq_mid", 32'(seq_cnt), 32'h1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("mix_bank1",   32'(wr_en),   32'h0002);
        chk("mix_wr_data", wr_data,      32'hA2);
        chk("mix_seq_end", 32'(seq_cnt), 32'h2);
        tick();

        // Walk counter to 7, then clear together with an auto accept.
        in_valid = 1'b1;
        in_auto  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 32'hB0 + 32'(k);
            tick();
        end
        in_data = 32'h777;
        cnt_clr = 1'b1;
        #1;
        chk("clr_pre_seq", 32'(seq_cnt), 32'h7);
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_wr_en",   32'(wr_en),   32'h0080);
        chk("clr_wr_data", wr_data,      32'h777);
        chk("clr_seq_cnt", 32'(seq_cnt), 32'h0);
`ifdef BANK_WRITE_DISPATCH_STAT_EN
        chk("clr_stat_wr",    32'(stat_wr_cnt),    32'h0);
        chk("clr_stat_stall", 32'(stat_stall_cnt), 32'h0);
`endif
        tick();

        // Reset while a word to bank 4 is stalled.
        in_valid = 1'b1;
        in_auto  = 1'b0;
        in_sel   = 4'd4;
        in_data  = 32'h444;
        tick();
        in_valid   = 1'b0;
        bank_stall = 16'h0010;
        #1;
        chk("rst_mid_stalled", 32'(in_ready), 32'h0);
`ifdef BANK_WRITE_DISPATCH_STAT_EN
        chk("pre_rst_stat_wr", 32'(stat_wr_cnt), 32'h1);
`endif
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        bank_stall = '0;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en),    32'h0);
        chk("rst_mid_ready", 32'(in_ready), 32'h1);
        tick();
        chk("rst_mid_wr_en2", 32'(wr_en),   32'h0);
        chk("rst_mid_seq",    32'(seq_cnt), 32'h0);
`ifdef BANK_WRITE_DISPATCH_STAT_EN
        chk("rst_stat_wr",    32'(stat_wr_cnt),    32'h0);
        chk("rst_stat_stall", 32'(stat_stall_cnt), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
